// File: rtl/nn_pkg.sv
// Shared types and default widths for the neural-network datapath blocks
// (fully-connected layer and ReLU stage).
package nn_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIXED_PNT  = 8;
    localparam int DEF_IN_SIZE    = 64;
    localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + $clog2(DEF_IN_SIZE) + 1;

    typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;
    typedef logic signed [DEF_ACC_WIDTH-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } fc_state_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Single-lane bias add, round-half-up to FIXED_PNT fractional bits and
// saturation to the signed DATA_WIDTH range.
module fxp_round_sat #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 39,
    parameter int FIXED_PNT  = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] res,
    output logic                         sat
);

    // One guard bit so the bias/rounding add can never wrap.
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic signed [SUM_W-1:0] RND_C   = {{(SUM_W-1){1'b0}}, 1'b1} << (FIXED_PNT - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] shr_s;

    assign sum_s = SUM_W'(acc) + (SUM_W'(bias) <<< FIXED_PNT) + RND_C;
    assign shr_s = sum_s >>> FIXED_PNT;

    // Clamp the rounded value into the output range and flag clipping.
    always_comb begin
        res = shr_s[DATA_WIDTH-1:0];
        sat = 1'b0;
        if (shr_s > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (shr_s < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else begin
            res = shr_s[DATA_WIDTH-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/fc_mac_layer.sv
// Sequential fully-connected layer: streams one weight column per cycle into
// VEC_SIZE parallel accumulators, then rounds/saturates with bias into vec_out.
module fc_mac_layer
    import nn_pkg::*;
#(
    parameter int IN_SIZE    = 64,
    parameter int VEC_SIZE   = 64,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIXED_PNT  = DEF_FIXED_PNT,
    parameter int ADDR_WIDTH = $clog2(IN_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] vec_in [IN_SIZE],
    input  logic signed [DATA_WIDTH-1:0] bias [VEC_SIZE],
    output logic                         w_rd_en,
    output logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic signed [DATA_WIDTH-1:0] w_data [VEC_SIZE],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] vec_out [VEC_SIZE],
    output logic                         sat_flag
);

    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(IN_SIZE) + 1;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IN_SIZE - 1);

    fc_state_e state_r, state_nx_s;

    logic                         in_ready_r, out_valid_r, sat_flag_r;
    logic                         w_rd_en_r, rd_pend_r;
    logic [ADDR_WIDTH-1:0]        w_addr_r, acc_cnt_r;
    logic signed [DATA_WIDTH-1:0] x_r       [IN_SIZE];
    logic signed [ACC_WIDTH-1:0]  acc_r     [VEC_SIZE];
    logic signed [PROD_WIDTH-1:0] prod_s    [VEC_SIZE];
    logic signed [DATA_WIDTH-1:0] rnd_s     [VEC_SIZE];
    logic signed [DATA_WIDTH-1:0] vec_out_r [VEC_SIZE];
    logic [VEC_SIZE-1:0]          lane_sat_s;
    logic                         accept_s, last_acc_s;

    assign accept_s   = in_valid & in_ready_r;
    // rd_pend_r marks the cycle in which w_data carries the column read one cycle earlier.
    assign last_acc_s = rd_pend_r && (acc_cnt_r == LAST_COL);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign w_rd_en   = w_rd_en_r;
    assign w_addr    = w_addr_r;
    assign vec_out   = vec_out_r;
    assign sat_flag  = sat_flag_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    if (accept_s)   state_nx_s = ACCUM; else state_nx_s = IDLE;
            ACCUM:   if (last_acc_s) state_nx_s = FINAL; else state_nx_s = ACCUM;
            FINAL:   state_nx_s = OUT;
            OUT:     if (out_ready)  state_nx_s = IDLE;  else state_nx_s = OUT;
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake flags and weight-read sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            w_rd_en_r   <= 1'b0;
            rd_pend_r   <= 1'b0;
            w_addr_r    <= '0;
        end else begin
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == OUT);
            rd_pend_r   <= w_rd_en_r;
            if (accept_s) begin
                w_rd_en_r <= 1'b1;
                w_addr_r  <= '0;
            end else if (w_rd_en_r) begin
                if (w_addr_r == LAST_COL) begin
                    w_rd_en_r <= 1'b0;
                end else begin
                    w_addr_r <= w_addr_r + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Per-lane products of the arriving column with the matching activation.
    always_comb begin
        for (int i = 0; i < VEC_SIZE; i++) begin
            prod_s[i] = PROD_WIDTH'(w_data[i]) * PROD_WIDTH'(x_r[acc_cnt_r]);
        end
    end

    // Input latch, accumulators and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_r  <= '0;
            sat_flag_r <= 1'b0;
            for (int j = 0; j < IN_SIZE; j++) x_r[j] <= '0;
            for (int i = 0; i < VEC_SIZE; i++) begin
                acc_r[i]     <= '0;
                vec_out_r[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                x_r       <= vec_in;
                acc_cnt_r <= '0;
                for (int i = 0; i < VEC_SIZE; i++) acc_r[i] <= '0;
            end else if ((state_r == ACCUM) && rd_pend_r) begin
                acc_cnt_r <= acc_cnt_r + ADDR_WIDTH'(1);
                for (int i = 0; i < VEC_SIZE; i++) begin
                    acc_r[i] <= acc_r[i] + ACC_WIDTH'(prod_s[i]);
                end
            end
            if (state_r == FINAL) begin
                vec_out_r  <= rnd_s;
                sat_flag_r <= |lane_sat_s;
            end
        end
    end

    for (genvar g = 0; g < VEC_SIZE; g++) begin : g_lane
        fxp_round_sat #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FIXED_PNT  (FIXED_PNT)
        ) u_round_sat (
            .acc  (acc_r[g]),
            .bias (bias[g]),
            .res  (rnd_s[g]),
            .sat  (lane_sat_s[g])
        );
    end

endmodule

// File: doc/fc_mac_layer.md
Name: fc_mac_layer

Overview:
- Sequential fully-connected layer: computes vec_out = W·vec_in + bias in signed fixed point (FIXED_PNT fractional bits).
- Output goes directly to the combinational ReLU stage, which consumes vec_out[VEC_SIZE].
- Streams one weight column per cycle from external weight memory. Holds VEC_SIZE parallel accumulators. Uses a valid/ready handshake on both sides.

Parameters:
- IN_SIZE, 64, input vector length (weight columns).
- VEC_SIZE, 64, output vector length (neurons); matches the ReLU VEC_SIZE.
- DATA_WIDTH, 16, signed data/weight/bias width.
- FIXED_PNT, 8, fractional bits of all operands; must be ≥1.
- ADDR_WIDTH, $clog2(IN_SIZE), weight column address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  vec_in is valid.
- in_ready  output  1  block can accept vec_in.
- vec_in  input  signed [DATA_WIDTH-1:0] [IN_SIZE]  input activations.
- bias  input  signed [DATA_WIDTH-1:0] [VEC_SIZE]  per-neuron bias; static during a transaction.
- w_rd_en  output  1  weight column read strobe.
- w_addr  output  ADDR_WIDTH  column index j.
- w_data  input  signed [DATA_WIDTH-1:0] [VEC_SIZE]  W[i][j] for all i; valid exactly 1 cycle after w_rd_en.
- out_valid  output  1  vec_out is valid.
- out_ready  input  1  downstream accepts vec_out.
- vec_out  output  signed [DATA_WIDTH-1:0] [VEC_SIZE]  result, to the ReLU stage.
- sat_flag  output  1  at least one lane of the current vec_out saturated.

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0 while rst_n=0, then 1 from the first cycle after deassertion. out_valid=0, w_rd_en=0, w_addr=0, vec_out all 0, sat_flag=0, accumulators 0.
- FSM states: IDLE → ACCUM → FINAL → OUT → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T0: latch vec_in into x_reg, clear accumulators and counters, go to ACCUM.
- ACCUM (cycles T1..T(IN_SIZE+1)):
  - Read side: w_rd_en=1 during T1..T(IN_SIZE), with w_addr = cycle−1.
  - Accumulate side: at cycle T(j+2), w_data is column j; acc[i] += w_data[i]*x_reg[j] for all i.
  - Read counter and accumulate counter are separate. The state exits after column IN_SIZE−1 is accumulated.
  - w_rd_en=0 on the final ACCUM cycle.
- FINAL (T(IN_SIZE+2)):
  - Per lane: r = (acc + (bias<<FIXED_PNT) + 2^(FIXED_PNT−1)) >>> FIXED_PNT, i.e. round half toward +inf.
  - Saturate r to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Register the results into vec_out. sat_flag = OR of the per-lane saturation flags.
- OUT:
  - out_valid=1 from T(IN_SIZE+3). Accept-to-valid latency is IN_SIZE+3 cycles.
  - vec_out and sat_flag stay stable until out_valid&out_ready.
  - On handshake: out_valid←0 and go to IDLE. in_ready=1 on the next cycle.
  - vec_out holds its last value after the handshake; it is not cleared.
- Arithmetic widths:
  - Product: 2*DATA_WIDTH.
  - Accumulator: ACC_WIDTH = 2*DATA_WIDTH + $clog2(IN_SIZE) + 1, signed. The accumulator never wraps.
  - Bias is sign-extended to ACC_WIDTH before the shift.
- in_ready=0 in ACCUM, FINAL and OUT. in_valid in those states is ignored, not queued.
- in_valid held high across OUT→IDLE: the new vector is accepted in the first IDLE cycle.
- Reset mid-transaction (any state): immediate return to reset values. The partial result is discarded; no out_valid is produced.
- bias or w_data changes outside their sampling windows have no effect.

Decomposition:
- Package nn_pkg:
  - data_t (signed DATA_WIDTH).
  - acc_t (signed ACC_WIDTH).
  - fc_state_e enum {IDLE, ACCUM, FINAL, OUT}.
  - Constants DEF_DATA_WIDTH=16, DEF_FIXED_PNT=8, shared with relu.
- One sub-module: fxp_round_sat.
  - Single lane, combinational.
  - Inputs: acc, bias. Outputs: rounded/saturated data_t and a sat bit.
  - Instantiated VEC_SIZE times in a generate loop.

Test Plan:
- Bench params: IN_SIZE=VEC_SIZE=4, DATA_WIDTH=16, FIXED_PNT=8. Weight-memory model has 1-cycle latency.
1. Identity: W=diag(256), bias=0, vec_in=[256,−512,128,0] → vec_out=[256,−512,128,0], sat_flag=0; out_valid first high exactly 7 cycles after accept; w_addr sequence 0,1,2,3.
2. Bias only: W=0, bias=[256,−256,0,1] → vec_out=[256,−256,0,1].
3. Rounding: W[0][0]=128, W[1][0]=−128, W[2][0]=384, x=[1,0,0,0], bias 0 → vec_out[0..2]=[1,0,2].
4. Saturation:
   - All W=32767, x=32767 → every lane 32767, sat_flag=1.
   - x=−32768 → every lane −32768, sat_flag=1.
5. Backpressure: out_ready=0 for 5 cycles after out_valid → vec_out stable, in_ready=0, in_valid pulses ignored. Release → handshake; in_ready=1 the next cycle; a back-to-back vector is accepted and computed correctly.
6. Reset mid-ACCUM (rst_n low at cycle 2 after accept) → out_valid, w_rd_en and vec_out are 0 immediately. The following identity transaction matches scenario 1.
